fft_out_checker: RTL and testbench

//  Self-checking sink for the burst FFT/IFFT sim. Accepts the FFT core's output stream, drives the

---
 rtl/fft_out_checker_pkg.sv | 15 +
 rtl/fft_cplx_tol_cmp.sv | 28 ++
 rtl/fft_out_checker.sv | 147 ++++++++++++++
 tb/tb_fft_out_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_checker_pkg.sv
// Shared definitions for the FFT/IFFT output checkers: FSM encoding and default parameters.
package fft_out_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TOL        = 2;

endpackage

// File: rtl/fft_cplx_tol_cmp.sv
// Complex-sample tolerance compare: flags a mismatch when |dut-gold| exceeds TOL on either component.
module fft_cplx_tol_cmp
  import fft_out_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TOL        = DEF_TOL
) (
  input  logic [DATA_WIDTH-1:0] dut,
  input  logic [DATA_WIDTH-1:0] gold,
  output logic                  mismatch
);

  localparam int unsigned HW = DATA_WIDTH / 2;
  localparam logic [HW:0] TOL_V = (HW + 1)'(TOL);

  logic [HW:0] re_diff, im_diff;
  logic [HW:0] re_abs, im_abs;

  // One extra bit keeps the full-range difference (e.g. 32767 - -32768) exact.
  always_comb begin
    re_diff  = {dut[DATA_WIDTH-1], dut[DATA_WIDTH-1:HW]} - {gold[DATA_WIDTH-1], gold[DATA_WIDTH-1:HW]};
    im_diff  = {dut[HW-1], dut[HW-1:0]} - {gold[HW-1], gold[HW-1:0]};
    re_abs   = re_diff[HW] ? (~re_diff + 1'b1) : re_diff;
    im_abs   = im_diff[HW] ? (~im_diff + 1'b1) : im_diff;
    mismatch = (re_abs > TOL_V) || (im_abs > TOL_V);
  end

endmodule

// File: rtl/fft_out_checker.sv
// Self-checking sink for the FFT output stream: walks the golden ROM in lockstep with accepted
// samples, counts tolerance mismatches and reports frame status at end of frame.
module fft_out_checker
  import fft_out_checker_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TOL        = DEF_TOL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  len_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  chk_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_idx_q, first_err_idx_d;
  logic                  len_err_q, len_err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic beat, at_last, final_beat, mismatch;

  fft_cplx_tol_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .TOL       (TOL)
  ) u_cmp (
    .dut     (s1_data_q),
    .gold    (rom_data),
    .mismatch(mismatch)
  );

  assign s_ready  = (state_q == ST_RUN);
  assign rom_addr = idx_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  assign beat       = s_valid && s_ready;
  assign at_last    = (idx_q == LAST_IDX);
  assign final_beat = beat && (s_last || at_last);

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    state_d         = state_q;
    idx_d           = idx_q;
    s1_vld_d        = 1'b0;
    s1_data_d       = s1_data_q;
    s1_idx_d        = s1_idx_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    len_err_d       = len_err_q;
    done_d          = done_q;
    pass_d          = pass_q;

    // Stage-1 sample meets its golden word this cycle.
    if (s1_vld_q && mismatch) begin
      err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) first_err_idx_d = s1_idx_q;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_RUN;
          idx_d           = '0;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          len_err_d       = 1'b0;
          done_d          = 1'b0;
          pass_d          = 1'b0;
        end
      end
      ST_RUN: begin
        if (beat) begin
          s1_vld_d  = 1'b1;
          s1_data_d = s_data;
          s1_idx_d  = idx_q;
          if (!at_last) idx_d = idx_q + 1'b1;
        end
        if (final_beat) begin
          state_d   = ST_DRAIN;
          len_err_d = (s_last != at_last);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (err_cnt_d == '0) && !len_err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      s1_vld_q        <= 1'b0;
      s1_idx_q        <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      len_err_q       <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      s1_vld_q        <= s1_vld_d;
      s1_idx_q        <= s1_idx_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      len_err_q       <= len_err_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  // NOTE: sample payload is only consumed when s1_vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
  end

  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign len_err       = len_err_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_fft_out_checker.sv
// Scoreboard bench for fft_out_checker: driver pushes expected running error counts, a negedge
// monitor pops one per accepted beat and checks err_cnt two edges later.
module tb_fft_out_checker;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int TOL   = 2;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last;
  logic [DW-1:0] s_data, rom_data;
  logic          s_ready, busy, done, pass, len_err;
  logic [AW-1:0] rom_addr, first_err_idx;
  logic [AW:0]   err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];
  int delta_re[DEPTH];
  int delta_im[DEPTH];

  always #5 clk = ~clk;

  fft_out_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TOL(TOL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .len_err      (len_err)
  );

  function automatic logic [DW-1:0] gold_word(int i);
    logic [15:0] re, im;
    re = 16'(i * 97 - 20000);
    im = 16'(12345 - i * 61);
    return {re, im};
  endfunction

  // Golden ROM with a 1-cycle registered read.
  always @(posedge clk) rom_data <= gold_word(int'(rom_addr));

  function automatic logic [DW-1:0] dut_word(int i);
    logic [DW-1:0] g;
    logic [15:0]   re, im;
    g  = gold_word(i);
    re = g[31:16] + 16'(delta_re[i]);
    im = g[15:0] + 16'(delta_im[i]);
    return {re, im};
  endfunction

  function automatic bit is_bad(int i);
    logic [DW-1:0]      g, d;
    logic signed [15:0] gr, gi, dr, di;
    int                 ere, eim;
    g   = gold_word(i);
    d   = dut_word(i);
    gr  = g[31:16];
    gi  = g[15:0];
    dr  = d[31:16];
    di  = d[15:0];
    ere = int'(dr) - int'(gr);
    eim = int'(di) - int'(gi);
    if (ere < 0) ere = -ere;
    if (eim < 0) eim = -eim;
    return (ere > TOL) || (eim > TOL);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: beat seen before edge k lands in err_cnt after edge k+1.
  initial begin : monitor
    bit d1_v, d2_v, clr_p;
    int d1_val, d2_val, exp_err;
    d1_v = 0; d2_v = 0; clr_p = 0; d1_val = 0; d2_val = 0; exp_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d1_v = 0; d2_v = 0; clr_p = 0; exp_err = 0;
      end else begin
        if (d2_v) exp_err = d2_val;
        if (clr_p) exp_err = 0;
        d2_v   = d1_v;
        d2_val = d1_val;
        d1_v   = 0;
        if (s_valid && s_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_beat: accepted sample with empty scoreboard, expected none (t=%0t)", $time);
          end else begin
            d1_v   = 1;
            d1_val = exp_q.pop_front();
          end
        end
        clr_p = start;
        check("err_cnt_track", 32'(err_cnt), 32'(exp_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_deltas();
    for (int i = 0; i < DEPTH; i++) begin
      delta_re[i] = 0;
      delta_im[i] = 0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gappy);
    int run_err;
    run_err = 0;
    for (int i = 0; i < n; i++) begin
      if (gappy) begin
        while ($urandom_range(0, 1) == 0) begin
          s_valid = 1'b0;
          s_last  = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = dut_word(i);
      s_last  = (i == last_at);
      if (is_bad(i)) run_err++;
      exp_q.push_back(run_err);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Offer samples that must be refused.
  task automatic push_extra(input string name, input int k);
    for (int i = 0; i < k; i++) begin
      s_valid = 1'b1;
      s_data  = dut_word(i);
      check(name, s_ready, 0);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (!done && cnt < 20) begin
      tick();
      cnt++;
    end
    check(name, done, 1);
  endtask

  task automatic expect_status(input string tag, input bit e_pass, input int e_err,
                               input int e_first, input bit e_len);
    check({tag, "_pass"}, pass, 32'(e_pass));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(e_err));
    check({tag, "_first_err_idx"}, 32'(first_err_idx), 32'(e_first));
    check({tag, "_len_err"}, len_err, 32'(e_len));
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_len_err"}, len_err, 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_first_err_idx"}, 32'(first_err_idx), 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    clear_deltas();
    #1 rst = 1'b1;
    #2;
    expect_reset("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Exact match, back-to-back.
    do_start();
    check("run_busy", busy, 1);
    send_frame(DEPTH, DEPTH - 1, 1'b0);
    wait_done("exact_done");
    expect_status("exact", 1'b1, 0, 0, 1'b0);

    // Tolerance boundary: +2 passes, -3 fails.
    delta_re[5] = 2;
    delta_im[9] = -3;
    do_start();
    check("restart_done_clr", done, 0);
    check("restart_pass_clr", pass, 0);
    send_frame(DEPTH, DEPTH - 1, 1'b0);
    wait_done("tol_done");
    expect_status("tol", 1'b0, 1, 9, 1'b0);
    clear_deltas();

    // Gappy stream, matching data.
    do_start();
    send_frame(DEPTH, DEPTH - 1, 1'b1);
    wait_done("gappy_done");
    expect_status("gappy", 1'b1, 0, 0, 1'b0);

    // Short frame: s_last on index 511.
    do_start();
    send_frame(512, 511, 1'b0);
    check("short_len_err", len_err, 1);
    push_extra("short_refuse", 3);
    wait_done("short_done");
    expect_status("short", 1'b0, 0, 0, 1'b1);

    // Missing s_last: frame ends at DEPTH-1 anyway, 1025th sample refused.
    do_start();
    send_frame(DEPTH, -1, 1'b0);
    check("nolast_len_err", len_err, 1);
    push_extra("nolast_refuse", 1);
    wait_done("nolast_done");
    expect_status("nolast", 1'b0, 0, 0, 1'b1);

    // Reset mid-frame after 300 beats carrying 3 errors (one full-range sign flip).
    delta_re[10]  = 5;
    delta_re[50]  = 32768;
    delta_im[299] = -4;
    do_start();
    send_frame(300, -1, 1'b0);
    tick();
    tick();
    tick();
    check("mid_err_cnt", 32'(err_cnt), 3);
    check("mid_first_err_idx", 32'(first_err_idx), 10);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    expect_reset("midrst");
    tick();
    rst = 1'b0;
    tick();
    check("midrst_idle_ready", s_ready, 0);
    clear_deltas();
    do_start();
    send_frame(DEPTH, DEPTH - 1, 1'b0);
    wait_done("post_rst_done");
    expect_status("post_rst", 1'b1, 0, 0, 1'b0);

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
